// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the two-requester ALU scheduler:
// FSM state encoding, default widths and counter width.
package alu_scheduler_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CTRL_W_DEF = 4;
   localparam int CNT_W      = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; rr names the preferred requester.
// Ports: valid[1:0] requests, rr preference, grant[1:0] one-hot (or zero).
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       rr,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (rr == 1'b0) begin
         if (valid[0])      grant = 2'b01;
         else if (valid[1]) grant = 2'b10;
      end else begin
         if (valid[1])      grant = 2'b10;
         else if (valid[0]) grant = 2'b01;
      end
   end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external combinational ALU between two requesters.
// Ports: clk/reset (async, active-high); req_valid/req_ready/req_ctrl/
// req_src1/req_src2 per-requester request side; alu_control/alu_src1/
// alu_src2 registered ALU drive, alu_result ALU return; rsp_valid/
// rsp_ready/rsp_id/rsp_data response side; op_cnt0/op_cnt1 completion
// counters; busy high whenever an operation is outstanding.
module alu_scheduler
   import alu_scheduler_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [2*CTRL_W-1:0]   req_ctrl,
   input  logic [2*DATA_W-1:0]   req_src1,
   input  logic [2*DATA_W-1:0]   req_src2,
   output logic [CTRL_W-1:0]     alu_control,
   output logic [DATA_W-1:0]     alu_src1,
   output logic [DATA_W-1:0]     alu_src2,
   input  logic [DATA_W-1:0]     alu_result,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_id,
   output logic [DATA_W-1:0]     rsp_data,
   output logic [CNT_W-1:0]      op_cnt0,
   output logic [CNT_W-1:0]      op_cnt1,
   output logic                  busy
);

   state_e              state_q, state_d;
   logic                rr_q, rr_d;
   logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
   logic [DATA_W-1:0]   src1_q, src1_d;
   logic [DATA_W-1:0]   src2_q, src2_d;
   logic                gnt_id_q, gnt_id_d;
   logic                rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0]    op_cnt0_q, op_cnt0_d;
   logic [CNT_W-1:0]    op_cnt1_q, op_cnt1_d;

   logic [1:0]          grant;
   logic                grant_id;
   logic                accept;
   logic                rsp_fire;

   rr_arb2 u_arb (
      .valid (req_valid),
      .rr    (rr_q),
      .grant (grant)
   );

   assign grant_id = grant[1];
   assign accept   = (state_q == ST_IDLE) && (req_valid != 2'b00);
   assign rsp_fire = (state_q == ST_RESP) && rsp_ready;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)    state_d = ST_EXEC;
         ST_EXEC:                state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; the grant is only visible in IDLE
   always_comb begin
      req_ready = 2'b00;
      if (state_q == ST_IDLE) req_ready = grant;
      rsp_valid = (state_q == ST_RESP);
      busy      = (state_q != ST_IDLE);
   end

   // Datapath next values
   always_comb begin
      rr_d       = rr_q;
      ctrl_d     = ctrl_q;
      src1_d     = src1_q;
      src2_d     = src2_q;
      gnt_id_d   = gnt_id_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      op_cnt0_d  = op_cnt0_q;
      op_cnt1_d  = op_cnt1_q;

      if (accept) begin
         gnt_id_d = grant_id;
         if (grant_id) begin
            ctrl_d = req_ctrl[2*CTRL_W-1:CTRL_W];
            src1_d = req_src1[2*DATA_W-1:DATA_W];
            src2_d = req_src2[2*DATA_W-1:DATA_W];
         end else begin
            ctrl_d = req_ctrl[CTRL_W-1:0];
            src1_d = req_src1[DATA_W-1:0];
            src2_d = req_src2[DATA_W-1:0];
         end
      end

      // ALU inputs were registered at grant, so the result is valid here
      if (state_q == ST_EXEC) begin
         rsp_data_d = alu_result;
         rsp_id_d   = gnt_id_q;
      end

      // Hand priority to the other requester after each completion
      if (rsp_fire) begin
         rr_d = ~rsp_id_q;
         if (rsp_id_q) op_cnt1_d = op_cnt1_q + 1'b1;
         else          op_cnt0_d = op_cnt0_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q       <= 1'b0;
         ctrl_q     <= '0;
         src1_q     <= '0;
         src2_q     <= '0;
         gnt_id_q   <= 1'b0;
         rsp_id_q   <= 1'b0;
         rsp_data_q <= '0;
         op_cnt0_q  <= '0;
         op_cnt1_q  <= '0;
      end else begin
         rr_q       <= rr_d;
         ctrl_q     <= ctrl_d;
         src1_q     <= src1_d;
         src2_q     <= src2_d;
         gnt_id_q   <= gnt_id_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
         op_cnt0_q  <= op_cnt0_d;
         op_cnt1_q  <= op_cnt1_d;
      end
   end

   assign alu_control = ctrl_q;
   assign alu_src1    = src1_q;
   assign alu_src2    = src2_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_data    = rsp_data_q;
   assign op_cnt0     = op_cnt0_q;
   assign op_cnt1     = op_cnt1_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: stub add/sub ALU, transaction-level model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_alu_scheduler;

   localparam int DW = 32;
   localparam int CW = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [2*CW-1:0] req_ctrl;
   logic [2*DW-1:0] req_src1;
   logic [2*DW-1:0] req_src2;
   logic [CW-1:0]  alu_control;
   logic [DW-1:0]  alu_src1;
   logic [DW-1:0]  alu_src2;
   logic [DW-1:0]  alu_result;
   logic           rsp_valid;
   logic           rsp_ready;
   logic           rsp_id;
   logic [DW-1:0]  rsp_data;
   logic [15:0]    op_cnt0;
   logic [15:0]    op_cnt1;
   logic           busy;

   alu_scheduler #(.DATA_W(DW), .CTRL_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_ctrl    (req_ctrl),
      .req_src1    (req_src1),
      .req_src2    (req_src2),
      .alu_control (alu_control),
      .alu_src1    (alu_src1),
      .alu_src2    (alu_src2),
      .alu_result  (alu_result),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .op_cnt0     (op_cnt0),
      .op_cnt1     (op_cnt1),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Stub ALU: ctrl 1 subtracts, anything else adds
   assign alu_result = (alu_control == 4'd1) ? alu_src1 - alu_src2
                                             : alu_src1 + alu_src2;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // Phase counts cycles since a grant: 0 waiting, 1 ALU, 2 response.
   function automatic logic pick_id(logic [1:0] v, logic pref);
      if (v == 2'b11) return pref;
      return (v == 2'b10);
   endfunction

   int          m_phase = 0;
   logic        m_rr = 1'b0;
   logic [3:0]  m_ctrl = '0;
   logic [31:0] m_s1 = '0, m_s2 = '0, m_data = '0;
   logic        m_id = 1'b0, m_rsp_id = 1'b0;
   logic [15:0] m_cnt [2] = '{16'd0, 16'd0};
   logic        m_preload = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase  <= 0;
         m_rr     <= 1'b0;
         m_ctrl   <= '0;
         m_s1     <= '0;
         m_s2     <= '0;
         m_data   <= '0;
         m_id     <= 1'b0;
         m_rsp_id <= 1'b0;
         m_cnt[0] <= '0;
         m_cnt[1] <= '0;
      end else begin
         if (m_preload) m_cnt[1] <= 16'hFFFF;
         if (m_phase == 0) begin
            if (req_valid != 2'b00) begin
               m_id    <= pick_id(req_valid, m_rr);
               m_ctrl  <= req_ctrl[pick_id(req_valid, m_rr)*CW +: CW];
               m_s1    <= req_src1[pick_id(req_valid, m_rr)*DW +: DW];
               m_s2    <= req_src2[pick_id(req_valid, m_rr)*DW +: DW];
               m_phase <= 1;
            end
         end else if (m_phase == 1) begin
            m_data   <= (m_ctrl == 4'd1) ? m_s1 - m_s2 : m_s1 + m_s2;
            m_rsp_id <= m_id;
            m_phase  <= 2;
         end else if (rsp_ready) begin
            m_rr <= !m_rsp_id;
            m_cnt[m_rsp_id] <= m_cnt[m_rsp_id] + 16'd1;
            m_phase <= 0;
         end
      end
   end

   // Compare every cycle on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         logic [1:0] exp_rdy;
         exp_rdy = 2'b00;
         if (m_phase == 0) begin
            if (req_valid == 2'b11) exp_rdy = m_rr ? 2'b10 : 2'b01;
            else                    exp_rdy = req_valid;
         end
         chk("m_req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
         chk("m_busy", {31'd0, busy}, {31'd0, m_phase != 0});
         chk("m_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_phase == 2});
         chk("m_alu_control", {28'd0, alu_control}, {28'd0, m_ctrl});
         chk("m_alu_src1", alu_src1, m_s1);
         chk("m_alu_src2", alu_src2, m_s2);
         chk("m_op_cnt0", {16'd0, op_cnt0}, {16'd0, m_cnt[0]});
         chk("m_op_cnt1", {16'd0, op_cnt1}, {16'd0, m_cnt[1]});
         if (m_phase == 2) begin
            chk("m_rsp_data", rsp_data, m_data);
            chk("m_rsp_id", {31'd0, rsp_id}, {31'd0, m_rsp_id});
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(int i, logic [3:0] c, logic [31:0] a, logic [31:0] b);
      req_ctrl[i*CW +: CW] = c;
      req_src1[i*DW +: DW] = a;
      req_src2[i*DW +: DW] = b;
   endtask

   logic [1:0] exp_r [6] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
   logic       exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      reset = 1'b0;
      req_valid = 2'b00;
      req_ctrl = '0;
      req_src1 = '0;
      req_src2 = '0;
      rsp_ready = 1'b0;

      // Reset values
      #1 reset = 1'b1;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_op_cnt0", {16'd0, op_cnt0}, 32'd0);
      chk("rst_op_cnt1", {16'd0, op_cnt1}, 32'd0);
      chk("rst_alu_control", {28'd0, alu_control}, 32'd0);
      chk("rst_alu_src1", alu_src1, 32'd0);
      chk("rst_alu_src2", alu_src2, 32'd0);
      repeat (2) step();
      reset = 1'b0;

      // Single op: 5 + 3
      rsp_ready = 1'b1;
      drv(0, 4'd0, 32'd5, 32'd3);
      req_valid = 2'b01;
      @(negedge clk) chk("single_ready_T", {30'd0, req_ready}, 32'd1);
      step();
      req_valid = 2'b00;
      @(negedge clk) chk("single_valid_T1", {31'd0, rsp_valid}, 32'd0);
      step();
      @(negedge clk);
      chk("single_valid_T2", {31'd0, rsp_valid}, 32'd1);
      chk("single_data", rsp_data, 32'd8);
      chk("single_id", {31'd0, rsp_id}, 32'd0);
      step();
      @(negedge clk);
      chk("single_cnt0", {16'd0, op_cnt0}, 32'd1);
      chk("single_busy", {31'd0, busy}, 32'd0);

      // Contention from reset: 1+1 on req0, 9-4 on req1
      step();
      reset = 1'b1;
      drv(0, 4'd0, 32'd1, 32'd1);
      drv(1, 4'd1, 32'd9, 32'd4);
      req_valid = 2'b11;
      step();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("cont_ready", {30'd0, req_ready}, {30'd0, exp_r[i]});
         chk("cont_valid", {31'd0, rsp_valid}, {31'd0, exp_v[i]});
         if (i == 2) begin
            chk("cont_data0", rsp_data, 32'd2);
            chk("cont_id0", {31'd0, rsp_id}, 32'd0);
         end
         if (i == 5) begin
            chk("cont_data1", rsp_data, 32'd5);
            chk("cont_id1", {31'd0, rsp_id}, 32'd1);
         end
         step();
         if (i == 5) req_valid = 2'b00;
      end

      // Backpressure: 7+6 held 10 cycles while req1 waits
      rsp_ready = 1'b0;
      drv(0, 4'd0, 32'd7, 32'd6);
      drv(1, 4'd1, 32'd20, 32'd5);
      req_valid = 2'b11;
      @(negedge clk) chk("bp_ready", {30'd0, req_ready}, 32'd1);
      step();
      req_valid = 2'b10;
      @(negedge clk) chk("bp_exec_valid", {31'd0, rsp_valid}, 32'd0);
      step();
      repeat (10) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_data", rsp_data, 32'd13);
         chk("bp_id", {31'd0, rsp_id}, 32'd0);
         chk("bp_ready_held", {30'd0, req_ready}, 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      @(negedge clk) chk("bp_release_valid", {31'd0, rsp_valid}, 32'd1);
      step();
      @(negedge clk);
      chk("bp_next_ready", {30'd0, req_ready}, 32'd2);
      chk("bp_cnt0", {16'd0, op_cnt0}, 32'd2);
      step();
      req_valid = 2'b00;
      step();
      @(negedge clk);
      chk("bp_r1_data", rsp_data, 32'd15);
      chk("bp_r1_id", {31'd0, rsp_id}, 32'd1);
      step();
      @(negedge clk) chk("bp_cnt1", {16'd0, op_cnt1}, 32'd2);

      // Counter wrap plus subtract wrap (0 - 1)
      force dut.op_cnt1_d = 16'hFFFF;
      m_preload = 1'b1;
      @(posedge clk);
      #1;
      release dut.op_cnt1_d;
      m_preload = 1'b0;
      drv(1, 4'd1, 32'd0, 32'd1);
      req_valid = 2'b10;
      @(negedge clk);
      chk("wrap_preload", {16'd0, op_cnt1}, 32'h0000_FFFF);
      chk("wrap_ready", {30'd0, req_ready}, 32'd2);
      step();
      req_valid = 2'b00;
      step();
      @(negedge clk);
      chk("subwrap_data", rsp_data, 32'hFFFF_FFFF);
      chk("subwrap_id", {31'd0, rsp_id}, 32'd1);
      step();
      @(negedge clk) chk("wrap_cnt1", {16'd0, op_cnt1}, 32'd0);

      // Reset one cycle after grant
      step();
      drv(0, 4'd0, 32'd2, 32'd2);
      req_valid = 2'b01;
      @(negedge clk) chk("rexec_ready", {30'd0, req_ready}, 32'd1);
      step();
      req_valid = 2'b00;
      #2 reset = 1'b1;
      #1;
      chk("rexec_busy", {31'd0, busy}, 32'd0);
      chk("rexec_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rexec_cnt0", {16'd0, op_cnt0}, 32'd0);
      chk("rexec_cnt1", {16'd0, op_cnt1}, 32'd0);
      chk("rexec_src1", alu_src1, 32'd0);
      step();
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("rexec_no_rsp", {31'd0, rsp_valid}, 32'd0);
         chk("rexec_idle", {31'd0, busy}, 32'd0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
